// File: rtl/square_seq_if.sv
// Stream and command bundle for the square_seq generator.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready carry the producer/consumer handshake.
//
// Signals:
//   start, dir, x_start, x_end : sequence request, sampled by the producer while idle
//   busy, done                 : sequence status from the producer
//   out_valid, out_ready       : beat handshake
//   x_out, sq_out, last        : beat payload
//
// Modports:
//   master : the generator side (drives status and payload)
//   slave  : the requester/consumer side
interface square_seq_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 dir;
  logic [WIDTH-1:0]     x_start;
  logic [WIDTH-1:0]     x_end;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     x_out;
  logic [2*WIDTH-1:0]   sq_out;
  logic                 last;
  logic                 done;

  modport master (
    input  start, dir, x_start, x_end, out_ready,
    output busy, out_valid, x_out, sq_out, last, done
  );

  modport slave (
    output start, dir, x_start, x_end, out_ready,
    input  busy, out_valid, x_out, sq_out, last, done
  );
endinterface

// File: rtl/square_seq.sv
// Streams (x, x*x) pairs from a latched x_start toward x_end, up or down.
// Latency: first beat valid WIDTH edges after start is sampled, then one beat per transfer.
// Backpressure: payload and last hold while out_valid=1 and out_ready=0.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, dominates all other inputs
//   bus  : square_seq_if.master
//            start/dir/x_start/x_end in, sampled only while idle
//            busy/done status out
//            out_valid/out_ready handshake, x_out/sq_out/last payload
//
// WIDTH must be at least 2. The square is always 2*WIDTH bits wide.
module square_seq #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  square_seq_if.master bus
);

  localparam int SQW = 2 * WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [WIDTH-1:0] X_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] X_MAX     = {WIDTH{1'b1}};
  localparam logic [SQW-1:0]   SQ_ONE    = SQW'(1);
  localparam logic [CW-1:0]    ITER_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    ITER_ONE  = CW'(1);

  // Control state
  logic [1:0]        state;
  logic              busy_q;
  logic              done_q;

  // Request captured at start; later input changes are ignored
  logic              dir_q;
  logic [WIDTH-1:0]  x_start_q;
  logic [WIDTH-1:0]  x_end_q;

  // Shift-add multiplier used once per sequence to seed the first square
  logic [WIDTH-1:0]  mplier;
  logic [SQW-1:0]    mcand;
  logic [SQW-1:0]    acc;
  logic [CW-1:0]     iter_cnt;

  // Output beat registers
  logic              out_vld_q;
  logic [WIDTH-1:0]  x_q;
  logic [SQW-1:0]    sq_q;

  // Datapath
  logic [SQW-1:0]    acc_sum;
  logic [SQW-1:0]    twice_x;
  logic [SQW-1:0]    sq_up;
  logic [SQW-1:0]    sq_dn;
  logic [WIDTH-1:0]  x_step;
  logic              at_end;
  logic              at_limit;
  logic              last_c;
  logic              xfer;

  // One shift-add iteration: add the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end
  end

  // Incremental square update, always from the pre-step x:
  //   up:   (x+1)^2 = x^2 + 2x + 1
  //   down: (x-1)^2 = x^2 - 2x + 1
  // The down form may wrap in the intermediate term but the final value
  // is exact modulo 2^SQW and is never negative.
  assign twice_x = {{(SQW-WIDTH-1){1'b0}}, x_q, 1'b0};
  assign sq_up   = sq_q + twice_x + SQ_ONE;
  assign sq_dn   = sq_q - twice_x + SQ_ONE;
  assign x_step  = dir_q ? (x_q - X_ONE) : (x_q + X_ONE);

  // A sequence ends at x_end or at the range limit in the counting
  // direction, whichever comes first; it never wraps.
  assign at_end   = (x_q == x_end_q);
  assign at_limit = dir_q ? (x_q == '0) : (x_q == X_MAX);
  assign last_c   = out_vld_q & (at_end | at_limit);

  assign xfer = out_vld_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
      x_start_q <= '0;
      x_end_q   <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      iter_cnt  <= '0;
      out_vld_q <= 1'b0;
      x_q       <= '0;
      sq_q      <= '0;
    end else begin
      // done is a single-cycle pulse; only the final transfer raises it.
      done_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_INIT;
            busy_q    <= 1'b1;
            dir_q     <= bus.dir;
            x_start_q <= bus.x_start;
            x_end_q   <= bus.x_end;
            mplier    <= bus.x_start;
            mcand     <= {{WIDTH{1'b0}}, bus.x_start};
            acc       <= '0;
            iter_cnt  <= ITER_LOAD;
          end
        end

        ST_INIT: begin
          acc      <= acc_sum;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          iter_cnt <= iter_cnt - ITER_ONE;
          // The edge doing the final iteration also presents the first beat,
          // using the just-completed sum rather than the stale accumulator.
          if (iter_cnt == ITER_ONE) begin
            state     <= ST_RUN;
            x_q       <= x_start_q;
            sq_q      <= acc_sum;
            out_vld_q <= 1'b1;
          end
        end

        ST_RUN: begin
          if (xfer) begin
            if (last_c) begin
              // x_q/sq_q keep the final beat's values after the sequence ends.
              state     <= ST_IDLE;
              out_vld_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              x_q  <= x_step;
              sq_q <= dir_q ? sq_dn : sq_up;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_vld_q;
  assign bus.x_out     = x_q;
  assign bus.sq_out    = sq_q;
  assign bus.last      = last_c;

endmodule
